// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - two-requester burst arbiter for the shared backing-memory port
//
// Grants the memory port to the i-cache (line fill) or the d-cache (line fill or
// write-back) for one BLOCK_WORDS burst at a time.
// A tie between requesters goes to the one not served last.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req, i_addr                     i-cache line-fill request and line address
//   i_word_valid, i_word_idx,         per-word fill delivery to the i-cache
//   i_rdata, i_done                   and end-of-burst pulse
//   d_req, d_we, d_addr, d_wline      d-cache request, direction, line address, write-back line
//   d_word_valid, d_word_idx,         per-word fill delivery to the d-cache
//   d_rdata, d_done                   and end-of-burst pulse
//   mem_en, mem_we, mem_addr,         memory-side word access
//   mem_wdata, mem_rdata, mem_ready   mem_ready completes the current word
module memory_port_arbiter #(
    parameter int ADDR_WIDTH  = 17,
    parameter int LEN         = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int BLOCK_IDX   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    output logic                       i_word_valid,
    output logic [BLOCK_IDX-1:0]       i_word_idx,
    output logic [LEN-1:0]             i_rdata,
    output logic                       i_done,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [ADDR_WIDTH-1:0]      d_addr,
    input  logic [LEN*BLOCK_WORDS-1:0] d_wline,
    output logic                       d_word_valid,
    output logic [BLOCK_IDX-1:0]       d_word_idx,
    output logic [LEN-1:0]             d_rdata,
    output logic                       d_done,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [LEN-1:0]             mem_wdata,
    input  logic [LEN-1:0]             mem_rdata,
    input  logic                       mem_ready
);

    localparam int OFF = BLOCK_IDX + 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
    localparam logic [BLOCK_IDX-1:0]  LAST_WORD = BLOCK_IDX'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic                       owner_d;
    logic                       last_d;
    logic                       we_r;
    logic [BLOCK_IDX-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]      base;
    logic [LEN*BLOCK_WORDS-1:0] line;

    logic                       grant_any;
    logic                       grant_d;
    logic                       grant_we;
    logic [ADDR_WIDTH-1:0]      grant_base;
    logic [BLOCK_IDX-1:0]       cnt_inc;
    logic [ADDR_WIDTH-1:0]      next_addr;
    logic [LEN-1:0]             next_wdata;

    // Grant choice and next-word address/data.
    always_comb begin
        grant_any  = i_req | d_req;
        grant_d    = (i_req && d_req) ? ~last_d : d_req;
        grant_we   = grant_d & d_we;
        grant_base = (grant_d ? d_addr : i_addr) & LINE_MASK;
        cnt_inc    = cnt + 1'b1;
        // base has its low OFF bits clear, so the offset never carries past the line.
        next_addr  = base + {{(ADDR_WIDTH-OFF){1'b0}}, cnt_inc, 2'b00};
        // line is held at zero for fills, so fills drive zero write data.
        next_wdata = line[int'(cnt_inc)*LEN +: LEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_BUSY;
            S_BUSY:  if (mem_ready && cnt == LAST_WORD) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // All outputs are registered; word_valid and done default low so they pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d      <= 1'b0;
            last_d       <= 1'b1;
            we_r         <= 1'b0;
            cnt          <= '0;
            base         <= '0;
            line         <= '0;
            i_word_valid <= 1'b0;
            i_word_idx   <= '0;
            i_rdata      <= '0;
            i_done       <= 1'b0;
            d_word_valid <= 1'b0;
            d_word_idx   <= '0;
            d_rdata      <= '0;
            d_done       <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            i_word_valid <= 1'b0;
            d_word_valid <= 1'b0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner_d   <= grant_d;
                        last_d    <= grant_d;
                        we_r      <= grant_we;
                        base      <= grant_base;
                        line      <= grant_we ? d_wline : '0;
                        cnt       <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_we;
                        mem_addr  <= grant_base;
                        mem_wdata <= grant_we ? d_wline[LEN-1:0] : '0;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        if (!we_r) begin
                            if (owner_d) begin
                                d_word_valid <= 1'b1;
                                d_word_idx   <= cnt;
                                d_rdata      <= mem_rdata;
                            end else begin
                                i_word_valid <= 1'b1;
                                i_word_idx   <= cnt;
                                i_rdata      <= mem_rdata;
                            end
                        end
                        if (cnt != LAST_WORD) begin
                            cnt       <= cnt_inc;
                            mem_addr  <= next_addr;
                            mem_wdata <= next_wdata;
                        end else begin
                            cnt       <= '0;
                            mem_en    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                S_DONE: begin
                    cnt <= '0;
                    if (owner_d) d_done <= 1'b1;
                    else         i_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - randomized self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

    localparam int AW = 17;
    localparam int LEN = 32;
    localparam int BW = 4;
    localparam int BI = 2;

    logic            clk;
    logic            rst;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_word_valid;
    logic [BI-1:0]   i_word_idx;
    logic [LEN-1:0]  i_rdata;
    logic            i_done;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [LEN*BW-1:0] d_wline;
    logic            d_word_valid;
    logic [BI-1:0]   d_word_idx;
    logic [LEN-1:0]  d_rdata;
    logic            d_done;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [LEN-1:0]  mem_wdata;
    logic [LEN-1:0]  mem_rdata;
    logic            mem_ready;

    memory_port_arbiter #(
        .ADDR_WIDTH(AW), .LEN(LEN), .BLOCK_WORDS(BW), .BLOCK_IDX(BI)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_word_valid(i_word_valid), .i_word_idx(i_word_idx),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline),
        .d_word_valid(d_word_valid), .d_word_idx(d_word_idx),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: a burst is {owner, base, we, line};
    // word k goes to base + 4k (mod 2^AW) once the k-th ready is seen,
    // and the owner's done follows one cycle after the last word.
    // ------------------------------------------------------------------
    bit          m_active, m_tail, m_owner_d, m_last_d, m_we;
    int          m_k;
    int          m_base;
    logic [31:0] m_line [BW];

    logic        e_mem_en, e_mem_we, e_iv, e_dv, e_idone, e_ddone;
    logic [31:0] e_mem_addr, e_mem_wdata, e_idx, e_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_tail = 0; m_last_d = 1; m_k = 0;
            e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
            e_iv = 0; e_dv = 0; e_idone = 0; e_ddone = 0; e_idx = 0; e_rdata = 0;
        end else begin
            e_iv = 0; e_dv = 0; e_idone = 0; e_ddone = 0;
            if (!m_active) begin
                if (i_req || d_req) begin
                    m_owner_d = (i_req && d_req) ? !m_last_d : d_req;
                    m_last_d  = m_owner_d;
                    m_base    = (m_owner_d ? int'(d_addr) : int'(i_addr)) / 16 * 16;
                    m_we      = m_owner_d && d_we;
                    for (int k = 0; k < BW; k++)
                        m_line[k] = m_we ? d_wline[32*k +: 32] : 32'h0;
                    m_active = 1; m_tail = 0; m_k = 0;
                    e_mem_en = 1; e_mem_we = m_we;
                    e_mem_addr = m_base; e_mem_wdata = m_line[0];
                end
            end else if (m_tail) begin
                e_idone = !m_owner_d;
                e_ddone = m_owner_d;
                m_active = 0; m_tail = 0; m_k = 0;
            end else if (mem_ready) begin
                if (!m_we) begin
                    e_iv = !m_owner_d; e_dv = m_owner_d;
                    e_idx = m_k; e_rdata = mem_rdata;
                end
                m_k++;
                if (m_k == BW) begin
                    m_tail = 1;
                    e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
                end else begin
                    e_mem_addr  = (m_base + 4 * m_k) % (1 << AW);
                    e_mem_wdata = m_line[m_k];
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the reference.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            check_eq("mem_en", mem_en, e_mem_en);
            check_eq("mem_we", mem_we, e_mem_we);
            check_eq("mem_addr", mem_addr, e_mem_addr);
            check_eq("mem_wdata", mem_wdata, e_mem_wdata);
            check_eq("i_word_valid", i_word_valid, e_iv);
            check_eq("d_word_valid", d_word_valid, e_dv);
            check_eq("i_done", i_done, e_idone);
            check_eq("d_done", d_done, e_ddone);
            if (e_iv) begin
                check_eq("i_word_idx", i_word_idx, e_idx);
                check_eq("i_rdata", i_rdata, e_rdata);
            end
            if (e_dv) begin
                check_eq("d_word_idx", d_word_idx, e_idx);
                check_eq("d_rdata", d_rdata, e_rdata);
            end
        end
    end

    // Memory side: fresh random read data every cycle, ready per mode.
    int ready_mode = 0;
    int stall_left = 0;
    always begin
        @(posedge clk);
        #2;
        mem_rdata = $urandom;
        case (ready_mode)
            1: mem_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (m_active && !m_tail && m_k == 2 && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b1;
        endcase
    end

    logic [31:0] beat_addr [$];
    logic [31:0] beat_wdata [$];
    int nv_i, nv_d;
    int order [$];

    // Follow one burst to its done pulse, logging memory beats; drop req on done.
    task automatic collect(input bit want_d, input int limit);
        bit got;
        got = 0;
        beat_addr.delete(); beat_wdata.delete();
        nv_i = 0; nv_d = 0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            if (mem_en && mem_ready) begin
                beat_addr.push_back(32'(mem_addr));
                beat_wdata.push_back(mem_wdata);
            end
            nv_i += int'(i_word_valid);
            nv_d += int'(d_word_valid);
            if (want_d ? d_done : i_done) begin
                got = 1;
                if (want_d) d_req = 1'b0;
                else        i_req = 1'b0;
            end
        end
        check_eq("done_seen", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit quiet;
        int n;
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wline = '0;
        mem_rdata = 0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_i_done", i_done, 0);
        check_eq("rst_d_word_valid", d_word_valid, 0);
        rst = 1'b0;

        // i-cache fill from an unaligned address.
        @(negedge clk);
        i_req = 1; i_addr = 17'h0104;
        collect(0, 40);
        check_eq("fill_beats", beat_addr.size(), BW);
        for (int k = 0; k < BW && k < beat_addr.size(); k++)
            check_eq("fill_addr", beat_addr[k], 32'h100 + 32'(4 * k));
        check_eq("fill_ivalid_cnt", nv_i, BW);
        check_eq("fill_dvalid_cnt", nv_d, 0);

        // d-cache write-back.
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 17'h0200;
        d_wline = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        collect(1, 40);
        check_eq("wb_beats", beat_addr.size(), BW);
        for (int k = 0; k < BW && k < beat_addr.size(); k++) begin
            check_eq("wb_addr", beat_addr[k], 32'h200 + 32'(4 * k));
            check_eq("wb_wdata", beat_wdata[k], {8'hA0 + 8'(k), 8'hA0 + 8'(k), 16'(k)});
        end
        check_eq("wb_dvalid_cnt", nv_d, 0);
        d_we = 0;

        // Both held from reset: I, D, I, D.
        do_reset();
        order.delete();
        i_req = 1; i_addr = 17'h0500; d_req = 1; d_addr = 17'h0600;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            if (i_done) begin order.push_back(0); n++; if (n == 3) i_req = 0; end
            if (d_done) begin order.push_back(1); n++; if (n == 4) d_req = 0; end
        end
        check_eq("alt_count", n, 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            check_eq("alt_order", order[k], k % 2);
        i_req = 0; d_req = 0;

        // ready low three cycles on word 2.
        @(negedge clk);
        stall_left = 3; ready_mode = 2;
        i_req = 1; i_addr = 17'h0400;
        collect(0, 40);
        check_eq("stall_beats", beat_addr.size(), BW);
        if (beat_addr.size() > 2) check_eq("stall_addr2", beat_addr[2], 32'h408);
        check_eq("stall_ivalid_cnt", nv_i, BW);
        check_eq("stall_used", stall_left, 0);
        ready_mode = 0;

        // reset while cnt == 1.
        @(negedge clk);
        i_req = 1; i_addr = 17'h0300;
        quiet = 0;
        for (int c = 0; c < 20 && !quiet; c++) begin
            @(negedge clk);
            if (m_active && !m_tail && m_k == 1) quiet = 1;
        end
        check_eq("reach_cnt1", 32'(quiet), 1);
        rst = 1; i_req = 0;
        @(negedge clk);
        rst = 0;
        check_eq("abort_mem_en", mem_en, 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(i_done);
        end
        check_eq("abort_no_done", n, 0);
        i_req = 1; i_addr = 17'h0340;
        collect(0, 40);
        if (beat_addr.size() > 0) check_eq("restart_addr0", beat_addr[0], 32'h340);
        check_eq("restart_beats", beat_addr.size(), BW);

        // line at the top of the address space.
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 17'h1FFF0;
        collect(1, 40);
        for (int k = 0; k < BW && k < beat_addr.size(); k++)
            check_eq("top_addr", beat_addr[k], 32'h1FFF0 + 32'(4 * k));
        check_eq("top_dvalid_cnt", nv_d, BW);

        // Random traffic.
        ready_mode = 1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (i_req && i_done) begin
                i_req = 1'($urandom_range(0, 1));
                i_addr = AW'($urandom);
            end else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_addr = AW'($urandom);
            end
            if (d_req && d_done) begin
                d_req = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom); d_we = 1'($urandom_range(0, 1));
                d_wline = {$urandom, $urandom, $urandom, $urandom};
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1; d_addr = AW'($urandom); d_we = 1'($urandom_range(0, 1));
                d_wline = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        quiet = 0;
        for (int c = 0; c < 300 && !quiet; c++) begin
            @(negedge clk);
            if (i_done) i_req = 0;
            if (d_done) d_req = 0;
            if (!i_req && !d_req && !m_active) quiet = 1;
        end
        check_eq("drain", 32'(quiet), 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
